pipe_stage_skid: RTL and testbench

//  Parametrised pipeline-stage register with a valid/ready handshake, flush, and a 2-entry skid buffer.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/pipe_stage_skid.sv | 110 +++++++++++
 tb/tb_pipe_stage_skid.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage skid register.
package pipe_pkg;

  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} pipe_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00007013;

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, flush, a 2-entry skid buffer and
// saturating flush/bubble statistics counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_INSTR),
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_instr,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic [CNT_W-1:0]  o_flush_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  localparam int unsigned EntryW = ADDR_W + DATA_W;

  pipe_state_e       state_q, state_d;
  logic [EntryW-1:0] main_q, main_d;
  logic [EntryW-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              acc, xfer;

  // Ready depends only on registered state, so upstream never sees a path from i_ready.
  assign o_ready = (state_q != ST_FULL) & ~i_reset;
  assign o_valid = (state_q != ST_EMPTY);
  assign o_pc    = main_q[EntryW-1:DATA_W];
  assign o_instr = o_valid ? main_q[DATA_W-1:0] : BUBBLE;

  assign acc  = i_valid & o_ready;
  assign xfer = o_valid & i_ready;

  assign o_flush_cnt  = flush_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      // A same-cycle xfer has already been sampled downstream; the incoming beat is dropped.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_BUSY;
            main_d  = {i_pc, i_instr};
          end
        end
        ST_BUSY: begin
          if (acc && xfer) begin
            main_d = {i_pc, i_instr};
          end else if (acc) begin
            state_d = ST_FULL;
            skid_d  = {i_pc, i_instr};
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (i_flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (!o_valid && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_EMPTY;
      main_q       <= {ADDR_W'(0), BUBBLE};
      skid_q       <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table plus a FIFO scoreboard checked every cycle,
// with a second CNT_W=4 instance sharing the stimulus for counter saturation.
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP = 32'h00007013;

  logic        clk = 1'b0;
  logic        rst, v, rdy, fl;
  logic [31:0] pc_in, instr_in;
  logic        o_valid, o_ready, o_valid4, o_ready4;
  logic [31:0] o_pc, o_instr, o_pc4, o_instr4;
  logic [15:0] fcnt, bcnt;
  logic [3:0]  fcnt4, bcnt4;

  always #5 clk = ~clk;

  pipe_stage_skid #(.ADDR_W(32), .DATA_W(32), .BUBBLE(32'h00007013), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(v), .o_ready(o_ready), .i_pc(pc_in),
    .i_instr(instr_in), .i_flush(fl), .o_valid(o_valid), .i_ready(rdy), .o_pc(o_pc),
    .o_instr(o_instr), .o_flush_cnt(fcnt), .o_bubble_cnt(bcnt)
  );

  pipe_stage_skid #(.ADDR_W(32), .DATA_W(32), .BUBBLE(32'h00007013), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_valid(v), .o_ready(o_ready4), .i_pc(pc_in),
    .i_instr(instr_in), .i_flush(fl), .o_valid(o_valid4), .i_ready(rdy), .o_pc(o_pc4),
    .o_instr(o_instr4), .o_flush_cnt(fcnt4), .o_bubble_cnt(bcnt4)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} beat_t;
  typedef struct {
    logic r, v; logic [31:0] pc; logic rdy, fl;
    logic ev, erdy; logic [31:0] epc; int unsigned efc;
  } vec_t;

  beat_t       q[$];
  vec_t        vt[$];
  logic [31:0] last_pc_m;
  int unsigned bcnt_m, fcnt_m, bcnt4_m, fcnt4_m;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return p ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic vi, input logic [31:0] p, input logic ri,
                     input logic f, input logic ev, input logic er, input logic [31:0] ep,
                     input int unsigned efc);
    vt.push_back('{r, vi, p, ri, f, ev, er, ep, efc});
  endtask

  // One clock cycle: drive, sample at negedge, score against the FIFO model, advance.
  task automatic step(input logic r, input logic vi, input logic [31:0] p, input logic ri,
                      input logic f, output logic s_v, output logic s_r,
                      output logic [31:0] s_pc, output logic [31:0] s_instr,
                      output logic [15:0] s_fc);
    bit em_v, em_r, acc, xfer;
    rst = r; v = vi; pc_in = p; instr_in = instr_of(p); rdy = ri; fl = f;
    @(negedge clk);
    s_v = o_valid; s_r = o_ready; s_pc = o_pc; s_instr = o_instr; s_fc = fcnt;
    em_v = (q.size() != 0);
    em_r = (q.size() < 2) && !r;
    chk("sb o_valid", o_valid, em_v);
    chk("sb o_ready", o_ready, em_r);
    chk("sb4 o_valid", o_valid4, em_v);
    chk("sb4 o_ready", o_ready4, em_r);
    chk("sb bubble_cnt", bcnt, bcnt_m);
    chk("sb flush_cnt", fcnt, fcnt_m);
    chk("sb4 bubble_cnt", bcnt4, bcnt4_m);
    chk("sb4 flush_cnt", fcnt4, fcnt4_m);
    if (em_v) begin
      chk("sb o_pc", o_pc, q[0].pc);
      chk("sb o_instr", o_instr, q[0].instr);
      chk("sb4 o_pc", o_pc4, q[0].pc);
      last_pc_m = q[0].pc;
    end else begin
      chk("sb bubble instr", o_instr, NOP);
      chk("sb held pc", o_pc, last_pc_m);
      chk("sb4 bubble instr", o_instr4, NOP);
    end
    if (r) begin
      q.delete();
      last_pc_m = '0;
      bcnt_m = 0; fcnt_m = 0; bcnt4_m = 0; fcnt4_m = 0;
    end else begin
      acc  = vi && em_r;
      xfer = em_v && ri;
      if (xfer) void'(q.pop_front());
      if (f) begin
        q.delete();
        if (fcnt_m < 16'hFFFF) fcnt_m++;
        if (fcnt4_m < 15) fcnt4_m++;
      end else if (acc) begin
        q.push_back('{p, instr_of(p)});
      end
      if (!em_v) begin
        if (bcnt_m < 16'hFFFF) bcnt_m++;
        if (bcnt4_m < 15) bcnt4_m++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        s_v, s_r, hold, rv, rr, rf, rrst;
    logic [31:0] s_pc, s_instr, next_pc, rpc;
    logic [15:0] s_fc;

    // T1 .. T5 directed vectors: inputs, then expected pre-edge outputs.
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0,   0);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0,   0);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0,   0);
    add(0, 1, 32'h100, 1, 0, 0, 1, 32'h0,   0);
    add(0, 1, 32'h104, 1, 0, 1, 1, 32'h100, 0);
    add(0, 1, 32'h108, 1, 0, 1, 1, 32'h104, 0);
    add(0, 0, 32'h0,   1, 0, 1, 1, 32'h108, 0);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h108, 0);
    add(0, 1, 32'h200, 0, 0, 0, 1, 32'h108, 0);
    add(0, 1, 32'h204, 0, 0, 1, 1, 32'h200, 0);
    add(0, 0, 32'h0,   0, 0, 1, 0, 32'h200, 0);
    add(0, 0, 32'h0,   1, 0, 1, 0, 32'h200, 0);
    add(0, 0, 32'h0,   1, 0, 1, 1, 32'h204, 0);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h204, 0);
    add(0, 1, 32'h300, 0, 0, 0, 1, 32'h204, 0);
    add(0, 1, 32'h304, 0, 0, 1, 1, 32'h300, 0);
    add(0, 1, 32'h308, 0, 1, 1, 0, 32'h300, 0);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h300, 1);
    add(0, 1, 32'h310, 1, 0, 0, 1, 32'h300, 1);
    add(0, 1, 32'h314, 1, 1, 1, 1, 32'h310, 1);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h310, 2);
    add(0, 1, 32'h400, 0, 0, 0, 1, 32'h310, 2);
    add(1, 1, 32'h404, 0, 0, 1, 0, 32'h400, 2);
    add(1, 1, 32'h404, 0, 0, 0, 0, 32'h0,   0);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0,   0);
    add(0, 0, 32'h0,   1, 0, 0, 1, 32'h0,   0);

    // Two-cycle reset before any checking.
    rst = 1'b1; v = 1'b0; rdy = 1'b0; fl = 1'b0; pc_in = '0; instr_in = '0;
    q.delete(); last_pc_m = '0;
    bcnt_m = 0; fcnt_m = 0; bcnt4_m = 0; fcnt4_m = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].v, vt[i].pc, vt[i].rdy, vt[i].fl, s_v, s_r, s_pc, s_instr, s_fc);
      chk($sformatf("vec%0d o_valid", i), s_v, vt[i].ev);
      chk($sformatf("vec%0d o_ready", i), s_r, vt[i].erdy);
      chk($sformatf("vec%0d o_pc", i), s_pc, vt[i].epc);
      chk($sformatf("vec%0d o_instr", i), s_instr, vt[i].ev ? instr_of(vt[i].epc) : NOP);
      chk($sformatf("vec%0d flush_cnt", i), s_fc, vt[i].efc);
    end

    // T6: idle long enough for the 4-bit bubble counter to saturate.
    for (int i = 0; i < 20; i++) step(0, 0, 32'h0, 1, 0, s_v, s_r, s_pc, s_instr, s_fc);
    chk("t6 bubble_cnt4 saturated", bcnt4, 4'hF);
    step(0, 0, 32'h0, 1, 0, s_v, s_r, s_pc, s_instr, s_fc);
    chk("t6 bubble_cnt4 no wrap", bcnt4, 4'hF);
    chk("t6 bubble_cnt16", bcnt, 16'd23);

    // Random valid/ready/flush run; payload held stable while stalled.
    next_pc = 32'h1000; hold = 1'b0; rpc = '0; rv = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rrst = ($urandom_range(0, 149) == 0);
      rf   = ($urandom_range(0, 19) == 0);
      rr   = ($urandom_range(0, 2) != 0);
      if (!hold) begin
        rv  = ($urandom_range(0, 3) != 0);
        rpc = next_pc;
        next_pc += 32'd4;
      end
      step(rrst, rv, rpc, rr, rf, s_v, s_r, s_pc, s_instr, s_fc);
      hold = rv && !s_r && !rf && !rrst;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 0, s_v, s_r, s_pc, s_instr, s_fc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
